sata_oob_link_ctrl: RTL
=======================

// Module: sata_oob_link_ctrl
// PURPOSE
//  Host-side SATA out-of-band (OOB) link-initialisation controller. Sits directly above the
//  dual-lane GTP wrapper's SATA lane: drives its comm_start/comm_type/tx_elec_idle/tx data and
//  consumes its rx_status, rx_elec_idle and 32-bit rx data. Runs COMRESET->COMINIT->COMWAKE->ALIGN
//  handshake, then hands the TX path to the link layer and reports o_link_up.
// PARAMETERS
//  TIMEOUT_CYC   66000  cycles (880 us @ 75 MHz) any wait state may last before full retry
//  IDLE_GAP_CYC  8      cycles tx_elec_idle stays high after each comm_start pulse before re-check
//  ALIGN_RUN     3      consecutive non-ALIGN primitives required before link up
//  MAX_RETRIES   16     retry limit (used only with SATA_OOB_RETRY_LIMIT_EN)
// PORTS
//  clk               in   1   SATA user clock (75 MHz from GTP wrapper)
//  rst_n             in   1   synchronous, active-low reset
//  i_enable          in   1   0 = hold in RESET, 1 = run link-up
//  i_phy_ready       in   1   PLL detect AND lane reset-done from GTP wrapper
//  i_rx_status       in   3   GTP rx_status; bit2 = COMINIT seen, bit1 = COMWAKE seen
//  i_rx_elec_idle    in   1   receiver electrical idle
//  i_rx_data         in   32  decoded rx word
//  i_rx_char_is_k    in   4   K flags for i_rx_data
//  i_user_tx_data    in   32  link-layer tx word (used only in LINK_UP)
//  i_user_tx_char_is_k in 4   link-layer K flags
//  o_tx_comm_start   out  1   one-cycle OOB burst request
//  o_tx_comm_type    out  1   0 = COMRESET, 1 = COMWAKE; valid with o_tx_comm_start
//  o_tx_elec_idle    out  1   force tx electrical idle
//  o_tx_data         out  32  word to GTP encoder
//  o_tx_char_is_k    out  4   K flags to GTP encoder
//  o_link_up         out  1   OOB complete, TX owned by link layer
//  o_link_fail       out  1   retry limit exhausted (only with SATA_OOB_RETRY_LIMIT_EN)
// BEHAVIOUR
//  - All outputs registered. Reset: state RESET, comm_start 0, comm_type 0, tx_elec_idle 1,
//    tx_data 0, char_is_k 0, link_up 0, link_fail 0, timer 0, retry count 0.
//  - Primitives: ALIGN 32'h7B4A4ABC k=4'b0001; SYNC 32'hB5B5957C k=4'b0001; D10.2 32'h4A4A4A4A k=0.
//  - Primitive = i_rx_char_is_k==4'b0001; ALIGN match requires data AND k equal.
//  - States (timer clears on every transition; timer==TIMEOUT_CYC-1 in WAIT_* or SEND_D10_2 -> RESET, retry++):
//    RESET: elec_idle=1; i_enable & i_phy_ready -> SEND_COMRESET.
//    SEND_COMRESET: comm_start=1,type=0 for exactly 1 cycle -> WAIT_COMINIT.
//    WAIT_COMINIT: after IDLE_GAP_CYC; i_rx_status[2] -> WAIT_NO_COMINIT.
//    WAIT_NO_COMINIT: rx_status[2]==0 -> SEND_COMWAKE.
//    SEND_COMWAKE: comm_start=1,type=1 for 1 cycle -> WAIT_COMWAKE.
//    WAIT_COMWAKE: i_rx_status[1] -> WAIT_IDLE_RELEASE.
//    WAIT_IDLE_RELEASE: i_rx_elec_idle==0 -> SEND_D10_2.
//    SEND_D10_2: elec_idle=0, tx D10.2; ALIGN received -> SEND_ALIGN.
//    SEND_ALIGN: tx ALIGN; count consecutive non-ALIGN primitives; ALIGN resets count;
//      non-primitive words hold count; count==ALIGN_RUN -> LINK_UP. No timeout here.
//    LINK_UP: link_up=1, tx = i_user_tx_* (1-cycle latency); i_rx_elec_idle high for
//      IDLE_GAP_CYC consecutive cycles, i_phy_ready low, or i_enable low -> RESET (link_up 0 next cycle).
//  - i_enable low or i_phy_ready low in any state -> RESET next cycle; takes precedence over all.
//  - rx_status bit2 and bit1 both set in one cycle: state's own bit wins; other ignored.
//  - Timer saturates at TIMEOUT_CYC-1; retry counter 5 bits, saturating.
// CONFIGURATION
//  SATA_OOB_RETRY_LIMIT_EN defined: retry count reaching MAX_RETRIES parks in FAIL (elec_idle=1,
//  link_fail=1) until i_enable deasserts or rst_n. Undefined: unlimited retries, o_link_fail tied 0.
// STRUCTURE
//  sata_oob_pkg: state enum, ALIGN/SYNC/D10.2 words and K masks, rx_status bit indices.
//  One sub-module sata_oob_timer: clearable saturating counter with terminal-count flag.
// TESTING
//  1 Device model answers COMINIT 20 cyc after COMRESET, COMWAKE 20 after COMWAKE, ALIGN then
//    3 SYNCs -> o_link_up=1, exactly 2 comm_start pulses (type 0 then 1).
//  2 No COMINIT ever -> after 66000 cyc return to RESET, second COMRESET pulse, retry=1.
//  3 ALIGN,SYNC,ALIGN,SYNC,SYNC,SYNC -> link_up only after third consecutive SYNC.
//  4 In LINK_UP, rx_elec_idle high 8 cyc -> link_up 0, new COMRESET issued; 7 cyc -> stays up.
//  5 i_enable dropped mid SEND_D10_2 -> RESET next cycle, tx_elec_idle=1.
//  6 With SATA_OOB_RETRY_LIMIT_EN, MAX_RETRIES=2, no device -> link_fail=1 after 2 timeouts.

Source files
------------

// File: rtl/sata_oob_pkg.sv
// Shared types and constants for the SATA OOB link controller: FSM states, primitive words,
// K-flag masks and rx_status bit positions.
package sata_oob_pkg;

  typedef enum logic [3:0] {
    StReset,
    StSendComreset,
    StWaitCominit,
    StWaitNoCominit,
    StSendComwake,
    StWaitComwake,
    StWaitIdleRelease,
    StSendD102,
    StSendAlign,
    StLinkUp,
    StFail
  } oob_state_e;

  localparam logic [31:0] AlignWord = 32'h7B4A4ABC;
  localparam logic [31:0] SyncWord  = 32'hB5B5957C;
  localparam logic [31:0] D102Word  = 32'h4A4A4A4A;
  localparam logic [3:0]  PrimK     = 4'b0001;
  localparam logic [3:0]  DataK     = 4'b0000;

  localparam int unsigned RxStatCominit = 2;
  localparam int unsigned RxStatComwake = 1;
  localparam int unsigned RetryW        = 5;

  function automatic logic is_align(input logic [31:0] data, input logic [3:0] k);
    return (data == AlignWord) && (k == PrimK);
  endfunction

endpackage

// File: rtl/sata_oob_timer.sv
// Clearable up-counter that saturates at MaxCount-1 and flags the terminal count.
module sata_oob_timer #(
  parameter int unsigned MaxCount = 66000,
  parameter int unsigned Width    = $clog2(MaxCount)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  localparam logic [Width-1:0] Last = Width'(MaxCount - 1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (count_q != Last) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == Last);

endmodule

// File: rtl/sata_oob_link_ctrl.sv
// Host-side SATA OOB controller: COMRESET -> COMINIT -> COMWAKE -> ALIGN, then link-layer TX.
// Define SATA_OOB_RETRY_LIMIT_EN to park in FAIL once MAX_RETRIES timeouts have occurred.
module sata_oob_link_ctrl
  import sata_oob_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC  = 66000,
  parameter int unsigned IDLE_GAP_CYC = 8,
  parameter int unsigned ALIGN_RUN    = 3,
  parameter int unsigned MAX_RETRIES  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_phy_ready,
  input  logic [2:0]  i_rx_status,
  input  logic        i_rx_elec_idle,
  input  logic [31:0] i_rx_data,
  input  logic [3:0]  i_rx_char_is_k,
  input  logic [31:0] i_user_tx_data,
  input  logic [3:0]  i_user_tx_char_is_k,
  output logic        o_tx_comm_start,
  output logic        o_tx_comm_type,
  output logic        o_tx_elec_idle,
  output logic [31:0] o_tx_data,
  output logic [3:0]  o_tx_char_is_k,
  output logic        o_link_up,
  output logic        o_link_fail
);

`ifdef SATA_OOB_RETRY_LIMIT_EN
  localparam bit LimitEn = 1'b1;
`else
  localparam bit LimitEn = 1'b0;
`endif

  localparam int unsigned TimerW    = $clog2(TIMEOUT_CYC);
  localparam int unsigned AlignCntW = $clog2(ALIGN_RUN + 1);
  localparam logic [TimerW-1:0]    IdleGap   = TimerW'(IDLE_GAP_CYC);
  localparam logic [TimerW-1:0]    IdleLast  = TimerW'(IDLE_GAP_CYC - 1);
  localparam logic [AlignCntW-1:0] AlignLast = AlignCntW'(ALIGN_RUN - 1);

  oob_state_e             state_q, state_d;
  logic [RetryW-1:0]      retry_q, retry_d;
  logic [AlignCntW-1:0]   align_cnt_q, align_cnt_d;
  logic [TimerW-1:0]      timer;
  logic                   timer_tc, timer_clr;
  logic                   rx_is_prim, rx_is_align;
  logic                   comm_start_q, comm_type_q, tx_elec_idle_q, link_up_q, link_fail_q;
  logic [31:0]            tx_data_q;
  logic [3:0]             tx_k_q;
  logic                   unused_rx_status;

  assign unused_rx_status = i_rx_status[0];
  assign rx_is_prim       = (i_rx_char_is_k == PrimK);
  assign rx_is_align      = is_align(i_rx_data, i_rx_char_is_k);

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    align_cnt_d = '0;
    unique case (state_q)
      StReset:           if (i_enable && i_phy_ready) state_d = StSendComreset;
      StSendComreset:    state_d = StWaitCominit;
      StWaitCominit: begin
        if (timer >= IdleGap && i_rx_status[RxStatCominit]) state_d = StWaitNoCominit;
      end
      StWaitNoCominit:   if (!i_rx_status[RxStatCominit]) state_d = StSendComwake;
      StSendComwake:     state_d = StWaitComwake;
      StWaitComwake:     if (i_rx_status[RxStatComwake]) state_d = StWaitIdleRelease;
      StWaitIdleRelease: if (!i_rx_elec_idle) state_d = StSendD102;
      StSendD102:        if (rx_is_align) state_d = StSendAlign;
      StSendAlign: begin
        // Non-primitive words neither advance nor break the run.
        align_cnt_d = align_cnt_q;
        if (rx_is_align) begin
          align_cnt_d = '0;
        end else if (rx_is_prim) begin
          if (align_cnt_q == AlignLast) state_d = StLinkUp;
          else align_cnt_d = align_cnt_q + 1'b1;
        end
      end
      StLinkUp:          if (i_rx_elec_idle && timer == IdleLast) state_d = StReset;
      StFail:            state_d = StFail;
      default:           state_d = StReset;
    endcase

    if (timer_tc && (state_q inside {StWaitCominit, StWaitNoCominit, StWaitComwake,
                                     StWaitIdleRelease, StSendD102})) begin
      retry_d = (retry_q == '1) ? retry_q : retry_q + 1'b1;
      state_d = (LimitEn && 32'(retry_d) >= MAX_RETRIES) ? StFail : StReset;
    end

    if (!i_enable) begin
      state_d = StReset;
      retry_d = '0;
    end else if (!i_phy_ready && state_q != StFail) begin
      state_d = StReset;
    end
  end

  // In LINK_UP the timer measures the current run of rx electrical idle.
  assign timer_clr = (state_d != state_q) || (state_q == StLinkUp && !i_rx_elec_idle);

  sata_oob_timer #(
    .MaxCount(TIMEOUT_CYC),
    .Width   (TimerW)
  ) u_timer (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (timer_clr),
    .count_o(timer),
    .tc_o   (timer_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StReset;
      retry_q        <= '0;
      align_cnt_q    <= '0;
      comm_start_q   <= 1'b0;
      comm_type_q    <= 1'b0;
      tx_elec_idle_q <= 1'b1;
      tx_data_q      <= '0;
      tx_k_q         <= '0;
      link_up_q      <= 1'b0;
      link_fail_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      retry_q        <= retry_d;
      align_cnt_q    <= align_cnt_d;
      comm_start_q   <= (state_d == StSendComreset) || (state_d == StSendComwake);
      comm_type_q    <= (state_d == StSendComwake);
      tx_elec_idle_q <= !(state_d inside {StSendD102, StSendAlign, StLinkUp});
      link_up_q      <= (state_d == StLinkUp);
      link_fail_q    <= LimitEn && (state_d == StFail);
      case (state_d)
        StSendD102: begin
          tx_data_q <= D102Word;
          tx_k_q    <= DataK;
        end
        StSendAlign: begin
          tx_data_q <= AlignWord;
          tx_k_q    <= PrimK;
        end
        StLinkUp: begin
          tx_data_q <= i_user_tx_data;
          tx_k_q    <= i_user_tx_char_is_k;
        end
        default: begin
          tx_data_q <= '0;
          tx_k_q    <= '0;
        end
      endcase
    end
  end

  assign o_tx_comm_start = comm_start_q;
  assign o_tx_comm_type  = comm_type_q;
  assign o_tx_elec_idle  = tx_elec_idle_q;
  assign o_tx_data       = tx_data_q;
  assign o_tx_char_is_k  = tx_k_q;
  assign o_link_up       = link_up_q;
  assign o_link_fail     = link_fail_q;

endmodule
